// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and types for the multi-port register file of the 9-bit ISA datapath.
// Contents:
//   RF_W, RF_D, RF_NR  default data width, address width and read-port count
//   rf_addr_t          register address type
//   rf_data_t          register data type
//   RF_RESET_VAL       default per-register reset preload (all zero)
package reg_file_pkg;

  localparam int unsigned RF_W  = 8;
  localparam int unsigned RF_D  = 4;
  localparam int unsigned RF_NR = 2;

  typedef logic [RF_D-1:0] rf_addr_t;
  typedef logic [RF_W-1:0] rf_data_t;

  localparam rf_data_t RF_RESET_VAL [2**RF_D] = '{default: '0};

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard for reg_file_mp. One bit per register marks a destination reserved by
// a multi-cycle unit; a writeback to that register clears it.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset (clears every pending bit)
//   WriteEnA/WaddrA       write port A; a write clears the target's pending bit
//   WriteEnB/WaddrB       write port B; same as A
//   IssueEn/IssueAddr     reserve a register; wins over a same-cycle write to it
//   Raddr                 packed read addresses, NR x D bits
//   Busy                  pending bit of each read address (stored state only)
//   AnyPending            OR of all pending bits
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned D       = RF_D,
  parameter int unsigned NR      = RF_NR,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEnA,
  input  logic [D-1:0]  WaddrA,
  input  logic          WriteEnB,
  input  logic [D-1:0]  WaddrB,
  input  logic          IssueEn,
  input  logic [D-1:0]  IssueAddr,
  input  logic [NR*D-1:0] Raddr,
  output logic [NR-1:0] Busy,
  output logic          AnyPending
);

  localparam int unsigned Depth = 2**D;

  logic [Depth-1:0] pending_d, pending_q;

  always_comb begin
    pending_d = pending_q;
    if (WriteEnA) pending_d[WaddrA] = 1'b0;
    if (WriteEnB) pending_d[WaddrB] = 1'b0;
    // Issue is applied last: a same-cycle issue is newer than the writeback.
    if (IssueEn) pending_d[IssueAddr] = 1'b1;
    if (R0_ZERO) pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    Busy = '0;
    for (int i = 0; i < NR; i++) begin
      Busy[i] = pending_q[Raddr[i*D +: D]];
    end
  end

  assign AnyPending = |pending_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, NR combinational read ports, per-register reset
// preload and a pending scoreboard (rf_scoreboard) for multi-cycle destinations.
// Optional macro RF_BYPASS_EN: same-cycle write data is forwarded to matching read ports and
// their Busy is forced low. Without it, reads show stored state only.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset (loads RESET_VAL, clears pending)
//   WriteEnA/WaddrA/DataInA  write port A (wins over B on an address clash)
//   WriteEnB/WaddrB/DataInB  write port B
//   IssueEn/IssueAddr     reserve a destination register
//   Raddr                 packed read addresses, port i = Raddr[i*D +: D]
//   DataOut               packed read data, port i = DataOut[i*W +: W]
//   Busy                  pending flag per read port
//   AnyPending            any register pending
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned W       = RF_W,
  parameter int unsigned D       = RF_D,
  parameter int unsigned NR      = RF_NR,
  parameter bit          R0_ZERO = 1'b0,
  parameter logic [W-1:0] RESET_VAL [2**D] = RF_RESET_VAL
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            WriteEnA,
  input  logic [D-1:0]    WaddrA,
  input  logic [W-1:0]    DataInA,
  input  logic            WriteEnB,
  input  logic [D-1:0]    WaddrB,
  input  logic [W-1:0]    DataInB,
  input  logic            IssueEn,
  input  logic [D-1:0]    IssueAddr,
  input  logic [NR*D-1:0] Raddr,
  output logic [NR*W-1:0] DataOut,
  output logic [NR-1:0]   Busy,
  output logic            AnyPending
);

  localparam int unsigned Depth = 2**D;

  logic [W-1:0]  regs_q [Depth];
  logic          wr_a, wr_b;
  logic [D-1:0]  rd_addr [NR];
  logic [NR-1:0] hit;
  logic [NR-1:0] sb_busy;

  // Port B is dropped when A targets the same register; address 0 is read-only zero if R0_ZERO.
  always_comb begin
    wr_a = WriteEnA && !(R0_ZERO && (WaddrA == '0));
    wr_b = WriteEnB && !(R0_ZERO && (WaddrB == '0)) && !(WriteEnA && (WaddrA == WaddrB));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= RESET_VAL[i];
      end
      if (R0_ZERO) regs_q[0] <= '0;
    end else begin
      if (wr_a) regs_q[WaddrA] <= DataInA;
      if (wr_b) regs_q[WaddrB] <= DataInB;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_addr[i] = Raddr[i*D +: D];
    end
  end

  always_comb begin
    DataOut = '0;
    hit     = '0;
    for (int i = 0; i < NR; i++) begin
      DataOut[i*W +: W] = regs_q[rd_addr[i]];
`ifdef RF_BYPASS_EN
      // No forwarding during Reset: those writes never commit.
      if (!Reset && WriteEnA && (WaddrA == rd_addr[i])) begin
        DataOut[i*W +: W] = DataInA;
        hit[i]            = 1'b1;
      end else if (!Reset && WriteEnB && (WaddrB == rd_addr[i])) begin
        DataOut[i*W +: W] = DataInB;
        hit[i]            = 1'b1;
      end
`endif
      if (R0_ZERO && (rd_addr[i] == '0)) begin
        DataOut[i*W +: W] = '0;
        hit[i]            = 1'b0;
      end
    end
  end

  rf_scoreboard #(
    .D       (D),
    .NR      (NR),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .Clk        (Clk),
    .Reset      (Reset),
    .WriteEnA   (WriteEnA),
    .WaddrA     (WaddrA),
    .WriteEnB   (WriteEnB),
    .WaddrB     (WaddrB),
    .IssueEn    (IssueEn),
    .IssueAddr  (IssueAddr),
    .Raddr      (Raddr),
    .Busy       (sb_busy),
    .AnyPending (AnyPending)
  );

  // A forwarded read carries the fresh result, so it is not busy.
  assign Busy = sb_busy & ~hit;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: two instances (R0_ZERO=0 and R0_ZERO=1) share all inputs.
// The driver predicts each cycle's outputs from an array model and queues them; a separate
// monitor pops and compares after the inputs settle.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 16;

  localparam logic [W-1:0] TB_RESET_VAL [DEPTH] = '{
    8'hC8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC8,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic Clk = 1'b0;
  logic Reset, WriteEnA, WriteEnB, IssueEn;
  logic [D-1:0] WaddrA, WaddrB, IssueAddr;
  logic [W-1:0] DataInA, DataInB;
  logic [NR*D-1:0] Raddr;
  logic [NR*W-1:0] dout0, dout1;
  logic [NR-1:0] busy0, busy1;
  logic any0, any1;

  always #5 Clk = ~Clk;

  reg_file_mp #(.W(W), .D(D), .NR(NR), .R0_ZERO(1'b0), .RESET_VAL(TB_RESET_VAL)) u_dut0 (
    .Clk(Clk), .Reset(Reset),
    .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
    .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .Raddr(Raddr),
    .DataOut(dout0), .Busy(busy0), .AnyPending(any0));

  reg_file_mp #(.W(W), .D(D), .NR(NR), .R0_ZERO(1'b1), .RESET_VAL(TB_RESET_VAL)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .WriteEnA(WriteEnA), .WaddrA(WaddrA), .DataInA(DataInA),
    .WriteEnB(WriteEnB), .WaddrB(WaddrB), .DataInB(DataInB),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .Raddr(Raddr),
    .DataOut(dout1), .Busy(busy1), .AnyPending(any1));

  typedef struct {
    logic [NR*W-1:0] d0, d1;
    logic [NR-1:0]   b0, b1;
    logic            a0, a1;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: index 0 -> R0_ZERO=0 instance, index 1 -> R0_ZERO=1 instance.
  logic [W-1:0] mreg [2][DEPTH];
  bit           mpend [2][DEPTH];

  function automatic bit is_zero_reg(input int k, input logic [D-1:0] a);
    return (k == 1) && (a == 0);
  endfunction

  function automatic void predict(input int k, output logic [NR*W-1:0] d,
                                  output logic [NR-1:0] b, output logic ap);
    logic [D-1:0] a;
    d = '0;
    b = '0;
    ap = 1'b0;
    for (int r = 0; r < DEPTH; r++) if (mpend[k][r]) ap = 1'b1;
    for (int i = 0; i < NR; i++) begin
      a = Raddr[i*D +: D];
      if (is_zero_reg(k, a)) begin
        d[i*W +: W] = '0;
        b[i] = 1'b0;
      end else begin
        d[i*W +: W] = mreg[k][a];
        b[i] = mpend[k][a];
`ifdef RF_BYPASS_EN
        if (!Reset && WriteEnA && WaddrA == a) begin
          d[i*W +: W] = DataInA;
          b[i] = 1'b0;
        end else if (!Reset && WriteEnB && WaddrB == a) begin
          d[i*W +: W] = DataInB;
          b[i] = 1'b0;
        end
`endif
      end
    end
  endfunction

  task automatic model_commit();
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        for (int r = 0; r < DEPTH; r++) begin
          mreg[k][r] = (k == 1 && r == 0) ? 8'h00 : TB_RESET_VAL[r];
          mpend[k][r] = 1'b0;
        end
      end else begin
        // B first, then A, so A's value is the one left on a clash.
        if (WriteEnB && !is_zero_reg(k, WaddrB)) mreg[k][WaddrB] = DataInB;
        if (WriteEnA && !is_zero_reg(k, WaddrA)) mreg[k][WaddrA] = DataInA;
        if (WriteEnA) mpend[k][WaddrA] = 1'b0;
        if (WriteEnB) mpend[k][WaddrB] = 1'b0;
        if (IssueEn && !is_zero_reg(k, IssueAddr)) mpend[k][IssueAddr] = 1'b1;
      end
    end
  endtask

  // Called right after a falling edge with this cycle's inputs already driven.
  task automatic step(input bit chk);
    exp_t e;
    #1;
    if (chk) begin
      predict(0, e.d0, e.b0, e.a0);
      predict(1, e.d1, e.b1, e.a1);
      exp_q.push_back(e);
    end
    model_commit();
    @(negedge Clk);
  endtask

  task automatic idle();
    Reset = 1'b0; WriteEnA = 1'b0; WriteEnB = 1'b0; IssueEn = 1'b0;
    WaddrA = '0; WaddrB = '0; IssueAddr = '0; DataInA = '0; DataInB = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle once inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dataout_r0z0", 32'(dout0), 32'(e.d0));
        check("busy_r0z0", 32'(busy0), 32'(e.b0));
        check("anypend_r0z0", 32'(any0), 32'(e.a0));
        check("dataout_r0z1", 32'(dout1), 32'(e.d1));
        check("busy_r0z1", 32'(busy1), 32'(e.b1));
        check("anypend_r0z1", 32'(any1), 32'(e.a1));
      end
    end
  end

  initial begin
    idle();
    Raddr = '0;
    Reset = 1'b1;
    step(1'b0);
    // Post-reset reads: preload values, nothing pending.
    idle(); Raddr = {4'd7, 4'd0}; step(1'b1);
    for (int a = 1; a < 7; a++) begin
      Raddr = {4'(a + 8), 4'(a)}; step(1'b1);
    end
    // Same-address double write: A wins.
    idle(); WriteEnA = 1; WaddrA = 3; DataInA = 8'h5A;
    WriteEnB = 1; WaddrB = 3; DataInB = 8'hA5; Raddr = {4'd3, 4'd3}; step(1'b1);
    idle(); WriteEnB = 1; WaddrB = 4; DataInB = 8'h11;
    WriteEnA = 1; WaddrA = 5; DataInA = 8'h22; Raddr = {4'd3, 4'd3}; step(1'b1);
    idle(); Raddr = {4'd5, 4'd4}; step(1'b1);
    // Scoreboard: issue, writeback, issue+write collision.
    idle(); IssueEn = 1; IssueAddr = 6; Raddr = {4'd6, 4'd6}; step(1'b1);
    idle(); Raddr = {4'd6, 4'd1}; step(1'b1);
    idle(); WriteEnA = 1; WaddrA = 6; DataInA = 8'h3C; Raddr = {4'd6, 4'd6}; step(1'b1);
    idle(); Raddr = {4'd6, 4'd6}; step(1'b1);
    idle(); IssueEn = 1; IssueAddr = 6; WriteEnB = 1; WaddrB = 6; DataInB = 8'h44;
    Raddr = {4'd6, 4'd6}; step(1'b1);
    idle(); Raddr = {4'd6, 4'd6}; step(1'b1);
    // Address 0 write and issue.
    idle(); WriteEnA = 1; WaddrA = 0; DataInA = 8'hFF; IssueEn = 1; IssueAddr = 0;
    Raddr = {4'd0, 4'd0}; step(1'b1);
    idle(); Raddr = {4'd0, 4'd6}; step(1'b1);
    // Same-cycle write/read of register 2.
    idle(); WriteEnA = 1; WaddrA = 2; DataInA = 8'h77; Raddr = {4'd2, 4'd0}; step(1'b1);
    idle(); Raddr = {4'd2, 4'd0}; step(1'b1);
    // Reset mid-operation with pending bits and an active write.
    idle(); IssueEn = 1; IssueAddr = 1; Raddr = {4'd9, 4'd1}; step(1'b1);
    idle(); IssueEn = 1; IssueAddr = 9; Raddr = {4'd9, 4'd1}; step(1'b1);
    idle(); Reset = 1; WriteEnA = 1; WaddrA = 7; DataInA = 8'h99; IssueEn = 1; IssueAddr = 4;
    Raddr = {4'd9, 4'd1}; step(1'b1);
    for (int a = 0; a < 8; a++) begin
      idle(); Raddr = {4'(a + 8), 4'(a)}; step(1'b1);
    end
    // Random traffic with deliberate address clashes.
    for (int n = 0; n < 600; n++) begin
      Reset     = ($urandom_range(0, 39) == 0);
      WriteEnA  = $urandom_range(0, 1) == 1;
      WriteEnB  = $urandom_range(0, 1) == 1;
      IssueEn   = $urandom_range(0, 2) == 0;
      WaddrA    = 4'($urandom_range(0, 15));
      WaddrB    = ($urandom_range(0, 3) == 0) ? WaddrA : 4'($urandom_range(0, 15));
      IssueAddr = ($urandom_range(0, 3) == 0) ? WaddrA : 4'($urandom_range(0, 15));
      DataInA   = 8'($urandom);
      DataInB   = 8'($urandom);
      Raddr[3:0] = ($urandom_range(0, 2) == 0) ? WaddrA : 4'($urandom_range(0, 15));
      Raddr[7:4] = ($urandom_range(0, 2) == 0) ? WaddrB : 4'($urandom_range(0, 15));
      step(1'b1);
    end
    idle();
    @(negedge Clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
